dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter sharing the single data-memory port between the RV32I core and a debug/loader master. Sits between the core's data-memory interface and the data memory. Core has default priority; a bounded starvation counter guarantees debug progress. Core stalls for any cycle it loses.

## Interface
- STARVE_MAX, 4: max consecutive contested cycles the core may win before debug is forced through; legal 1..15
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- core_read  in  1  core load request
- core_write  in  1  core store request
- core_addr  in  32  core byte address
- core_wdata  in  32  core store data
- core_store_type  in  2  core store size code, passed through
- core_load_type  in  3  core load size/sign code, passed through
- core_rdata  out  32  = mem_rdata (combinational)
- core_stall  out  1  core lost arbitration this cycle; core holds PC and re-presents request
- dbg_req  in  1  debug access request; held until dbg_gnt
- dbg_we  in  1  1 = store, 0 = load
- dbg_addr  in  32  debug byte address
- dbg_wdata  in  32  debug store data
- dbg_store_type  in  2  debug store size code
- dbg_load_type  in  3  debug load size code
- dbg_lock  in  1  hold port for a burst (present only with DMEM_ARB_LOCK_EN)
- dbg_gnt  out  1  debug access performed this cycle
- dbg_rdata  out  32  registered load data
- dbg_rvalid  out  1  dbg_rdata valid; one-cycle pulse
- mem_read, mem_write  out  1 each  to data memory
- mem_addr, mem_wdata  out  32 each  to data memory
- mem_store_type  out  2;  mem_load_type  out  3  to data memory
- mem_rdata  in  32  combinational read data from data memory

## Operation
- core_active = core_read | core_write.
- FSM states: ARB (reset state), LOCKED (macro only).
- ARB grant rule (combinational): dbg_gnt = dbg_req & (~core_active | starve_cnt == STARVE_MAX); else core owns the port.
- core_stall = core_active & dbg_gnt. A stalled core's write never reaches memory (mem_write driven by the owner only).
- Mux: dbg_gnt selects all dbg_* fields onto mem_*, mem_read = ~dbg_we, mem_write = dbg_we; otherwise core fields pass through unchanged.
- starve_cnt: clear when dbg_gnt or ~dbg_req; increment when dbg_req & core_active & ~dbg_gnt; saturates at STARVE_MAX. Width: 4 bits.
- dbg_rdata/dbg_rvalid: on a granted debug load, capture mem_rdata; dbg_rvalid = 1 the next cycle only. Granted debug store: dbg_rvalid stays 0.
- No request at all: mem_* mirror the core fields (read/write = 0).

## Timing
- Reset: state ARB, starve_cnt 0, dbg_rvalid 0, dbg_rdata 0; dbg_gnt, core_stall combinational, 0 unless dbg_req asserted.
- Uncontested debug: granted the same cycle dbg_req rises; load data 1 cycle later.
- Contested (core active every cycle): core wins STARVE_MAX cycles; debug granted on cycle STARVE_MAX+1 after dbg_req rises, with core_stall = 1 that cycle only.
- Simultaneous core + debug with starve_cnt == STARVE_MAX: debug wins, counter clears.
- dbg_req dropped before grant: counter clears, no grant.
- Reset asserted mid-lock or with dbg_rvalid pending: reset wins; pending dbg_rvalid is suppressed.

## Configuration
- DMEM_ARB_LOCK_EN defined: dbg_lock port exists. Debug grant with dbg_lock = 1 moves ARB -> LOCKED; in LOCKED dbg_gnt = dbg_req, core_stall = core_active every cycle, starve_cnt held at 0; dbg_lock = 0 at a clock edge returns to ARB. Core gets no access during LOCKED.
- Undefined: no dbg_lock port, no LOCKED state; ARB only.

## Test plan
- Reset held 2 cycles with core_read = 1 -> dbg_rvalid = 0, core_stall = 0, mem_read = 1, mem_addr = core_addr.
- Core idle, debug load from 0x100 containing 0xDEADBEEF -> dbg_gnt same cycle, next cycle dbg_rvalid = 1, dbg_rdata = 0xDEADBEEF.
- Core continuous loads, dbg_req held (STARVE_MAX = 4) -> dbg_gnt and core_stall high only on cycle 5; core address stable across that cycle.
- Contested debug store 0x12345678 to 0x40 while core stores 0xAAAA to 0x40 -> debug write lands on cycle 5; core write lands cycle 6 (final 0xAAAA); no write during stall from core.
- With DMEM_ARB_LOCK_EN, dbg_lock = 1 for 3 granted loads while core active -> core_stall = 1 for 3 cycles, then core resumes; reset mid-lock -> state ARB, dbg_rvalid 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Arbiter for the shared data-memory port. The core has default priority, and a starvation
// counter forces the debug master through. The debug burst lock is built with DMEM_ARB_LOCK_EN.
module dmem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_store_type,
  input  logic [2:0]  core_load_type,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [1:0]  dbg_store_type,
  input  logic [2:0]  dbg_load_type,
`ifdef DMEM_ARB_LOCK_EN
  input  logic        dbg_lock,
`endif
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_store_type,
  output logic [2:0]  mem_load_type,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic        core_active;
  logic        locked;
  logic        dbg_load_gnt;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        dbg_rvalid_q, dbg_rvalid_d;
  logic [31:0] dbg_rdata_q,  dbg_rdata_d;

  assign core_active = core_read | core_write;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic {ST_ARB, ST_LOCKED} state_e;
  state_e state_q, state_d;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:    if (dbg_gnt && dbg_lock) state_d = ST_LOCKED;
      ST_LOCKED: if (!dbg_lock)           state_d = ST_ARB;
      default:   state_d = ST_ARB;
    endcase
  end

  assign locked = (state_q == ST_LOCKED);
`else
  assign locked = 1'b0;
`endif

  // NOTE: every output is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    dbg_gnt    = locked ? dbg_req
                        : dbg_req & (~core_active | (starve_cnt_q == STARVE_LIM));
    core_stall = core_active & (dbg_gnt | locked);
    if (dbg_gnt) begin
      mem_read       = ~dbg_we;
      mem_write      = dbg_we;
      mem_addr       = dbg_addr;
      mem_wdata      = dbg_wdata;
      mem_store_type = dbg_store_type;
      mem_load_type  = dbg_load_type;
    end else begin
      // A stalled core must not leak a read or write into memory.
      mem_read       = core_read  & ~core_stall;
      mem_write      = core_write & ~core_stall;
      mem_addr       = core_addr;
      mem_wdata      = core_wdata;
      mem_store_type = core_store_type;
      mem_load_type  = core_load_type;
    end
  end

  assign dbg_load_gnt = dbg_gnt & ~dbg_we;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (locked || dbg_gnt || !dbg_req)
      starve_cnt_d = '0;
    else if (core_active && starve_cnt_q != STARVE_LIM)
      starve_cnt_d = starve_cnt_q + 4'd1;
    dbg_rvalid_d = dbg_load_gnt;
    dbg_rdata_d  = dbg_load_gnt ? mem_rdata : dbg_rdata_q;
  end

  // NOTE: the load-data register is reset too, because the debug master may read dbg_rdata out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign core_rdata = mem_rdata;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model and a reference memory.
module tb_dmem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_read = 1'b0, core_write = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [1:0]  core_store_type = '0;
  logic [2:0]  core_load_type = '0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [1:0]  dbg_store_type = '0;
  logic [2:0]  dbg_load_type = '0;
  logic        dbg_lock_v = 1'b0;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_store_type;
  logic [2:0]  mem_load_type;

  // Environment memory (drives the DUT) and the model's reference memory.
  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  assign mem_rdata = tb_mem[mem_addr[9:2]];

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int          m_wait = 0;
  bit          m_locked = 0;
  bit          m_rvalid = 0;
  logic [31:0] m_rdata = '0;
  // Expected combinational outputs for the current cycle.
  logic        exp_gnt, exp_stall, exp_mr, exp_mw;
  logic [31:0] exp_addr, exp_wdata;
  logic [1:0]  exp_st;
  logic [2:0]  exp_lt;

  dmem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_store_type(core_store_type), .core_load_type(core_load_type),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_store_type(dbg_store_type), .dbg_load_type(dbg_load_type),
`ifdef DMEM_ARB_LOCK_EN
    .dbg_lock(dbg_lock_v),
`endif
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_store_type(mem_store_type), .mem_load_type(mem_load_type), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs at the falling edge and compute the expected port ownership.
  task automatic drive(input logic rst, input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic lk);
    bit core_act;
    @(negedge clk);
    reset = rst; core_read = cr; core_write = cw; core_addr = ca; core_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd; dbg_lock_v = lk;
    core_store_type = 2'($urandom); core_load_type = 3'($urandom);
    dbg_store_type  = 2'($urandom); dbg_load_type  = 3'($urandom);
    #1;
    core_act  = cr | cw;
    exp_gnt   = m_locked ? dr : (dr && (!core_act || m_wait == STARVE_MAX));
    exp_stall = core_act && (exp_gnt || m_locked);
    if (exp_gnt) begin
      exp_mr = !dw; exp_mw = dw; exp_addr = da; exp_wdata = dd;
      exp_st = dbg_store_type; exp_lt = dbg_load_type;
    end else begin
      exp_mr = cr && !exp_stall; exp_mw = cw && !exp_stall; exp_addr = ca; exp_wdata = cd;
      exp_st = core_store_type; exp_lt = core_load_type;
    end
  endtask

  // Clock edge: advance the model, then let the environment memory commit a write.
  task automatic tick();
    logic        w;
    logic [31:0] wa, wd;
    bit          core_act;
    w = mem_write; wa = mem_addr; wd = mem_wdata;
    core_act = core_read | core_write;
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_locked = 0; m_rvalid = 0; m_rdata = '0;
    end else begin
      m_rvalid = exp_gnt && !dbg_we;
      if (m_rvalid) m_rdata = ref_mem[dbg_addr[9:2]];
      if (m_locked || exp_gnt || !dbg_req) m_wait = 0;
      else if (core_act && m_wait < STARVE_MAX) m_wait = m_wait + 1;
`ifdef DMEM_ARB_LOCK_EN
      if (!m_locked && exp_gnt && dbg_lock_v) m_locked = 1;
      else if (m_locked && !dbg_lock_v)       m_locked = 0;
`endif
    end
    if (exp_mw) ref_mem[exp_addr[9:2]] = exp_wdata;
    #1;
    if (w === 1'b1) tb_mem[wa[9:2]] = wd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 1, 0, 32'h200, 32'h0, 0, 0, 32'h0, 32'h0, 0);
      if (c == 1) begin
        total++;
        if ({core_stall, mem_read, dbg_gnt} !== 3'b010 || mem_addr !== 32'h200) begin
          bad++;
          $display("FAIL reset_comb: stall=%b rd=%b gnt=%b addr=%h want stall=0 rd=1 gnt=0 addr=00000200",
                   core_stall, mem_read, dbg_gnt, mem_addr);
        end
      end
      tick();
    end
    total++;
    if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs: rvalid=%b rdata=%h want 0/00000000", dbg_rvalid, dbg_rdata);
    end
  endtask

  task automatic test_uncontested();
    tb_mem[8'h40] = 32'hDEADBEEF; ref_mem[8'h40] = 32'hDEADBEEF;
    drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 0);
    total++;
    if (dbg_gnt !== 1'b1 || core_stall !== 1'b0 || mem_read !== 1'b1 || mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL uncontested_gnt: gnt=%b stall=%b rd=%b addr=%h want 1/0/1/00000100",
               dbg_gnt, core_stall, mem_read, mem_addr);
    end
    tick();
    total++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL uncontested_data: rvalid=%b rdata=%h want 1/deadbeef", dbg_rvalid, dbg_rdata);
    end
    idle();
    total++;
    if (dbg_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rvalid_pulse: rvalid=%b want 0", dbg_rvalid);
    end
  endtask

  task automatic test_contested_load();
    bit want;
    for (int c = 1; c <= 7; c++) begin
      drive(0, 1, 0, 32'h80, 32'h0, c <= STARVE_MAX + 1, 0, 32'h100, 32'h0, 0);
      want = (c == STARVE_MAX + 1);
      total++;
      if (dbg_gnt !== want || core_stall !== want || mem_addr !== (want ? 32'h100 : 32'h80)
          || core_addr !== 32'h80) begin
        bad++;
        $display("FAIL contested_load c=%0d: gnt=%b stall=%b addr=%h want gnt=stall=%b", c,
                 dbg_gnt, core_stall, mem_addr, want);
      end
      tick();
      total++;
      if (dbg_rvalid !== (c == STARVE_MAX + 1) || (dbg_rvalid && dbg_rdata !== 32'hDEADBEEF)) begin
        bad++;
        $display("FAIL contested_rvalid c=%0d: rvalid=%b rdata=%h", c, dbg_rvalid, dbg_rdata);
      end
    end
  endtask

  task automatic test_contested_store();
    bit want;
    for (int c = 1; c <= 6; c++) begin
      drive(0, 0, 1, 32'h40, 32'h0000AAAA, c <= STARVE_MAX + 1, 1, 32'h40, 32'h12345678, 0);
      want = (c == STARVE_MAX + 1);
      total++;
      if (core_stall !== want || mem_write !== 1'b1 || mem_addr !== 32'h40 ||
          mem_wdata !== (want ? 32'h12345678 : 32'h0000AAAA)) begin
        bad++;
        $display("FAIL contested_store c=%0d: stall=%b we=%b wdata=%h", c, core_stall, mem_write, mem_wdata);
      end
      tick();
      if (c >= STARVE_MAX + 1) begin
        total++;
        if (tb_mem[8'h10] !== (want ? 32'h12345678 : 32'h0000AAAA) || dbg_rvalid !== 1'b0) begin
          bad++;
          $display("FAIL store_landed c=%0d: mem=%h rvalid=%b", c, tb_mem[8'h10], dbg_rvalid);
        end
      end
    end
  endtask

  task automatic test_drop_before_grant();
    bit req, want;
    for (int c = 1; c <= 10; c++) begin
      req  = (c != 4) && (c <= 9);
      want = (c == 9);
      drive(0, 1, 0, 32'h84, 32'h0, req, 0, 32'h104, 32'h0, 0);
      total++;
      if (dbg_gnt !== want || core_stall !== want) begin
        bad++;
        $display("FAIL drop_before_grant c=%0d: gnt=%b stall=%b want %b", c, dbg_gnt, core_stall, want);
      end
      tick();
    end
  endtask

  task automatic test_reset_pending();
    drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 0);
    tick();
    drive(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 0);
    tick();
    total++;
    if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_pending: rvalid=%b rdata=%h want 0/00000000", dbg_rvalid, dbg_rdata);
    end
    idle();
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    bit want;
    for (int c = 1; c <= 9; c++) begin
      want = (c >= STARVE_MAX + 1) && (c <= STARVE_MAX + 3);
      drive(0, 1, 0, 32'h88, 32'h0, c <= STARVE_MAX + 3, 0, 32'h100, 32'h0, c < STARVE_MAX + 3);
      total++;
      if (dbg_gnt !== want || core_stall !== want || mem_read !== 1'b1) begin
        bad++;
        $display("FAIL lock_burst c=%0d: gnt=%b stall=%b rd=%b want gnt=stall=%b", c,
                 dbg_gnt, core_stall, mem_read, want);
      end
      tick();
    end
    drive(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h100, 32'h0, 1);
    tick();
    drive(1, 1, 0, 32'h88, 32'h0, 1, 0, 32'h100, 32'h0, 1);
    total++;
    if (dbg_gnt !== 1'b1 || core_stall !== 1'b1) begin
      bad++;
      $display("FAIL locked_hold: gnt=%b stall=%b want 1/1", dbg_gnt, core_stall);
    end
    tick();
    drive(0, 1, 0, 32'h88, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    total++;
    if (dbg_rvalid !== 1'b0 || core_stall !== 1'b0 || mem_read !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_lock: rvalid=%b stall=%b rd=%b want 0/0/1", dbg_rvalid, core_stall, mem_read);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    bit pend = 0, dw = 0, lk = 0;
    logic [31:0] da = '0, dd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1; dw = $urandom_range(0, 1) == 1;
        da = 32'($urandom_range(0, 15)) << 2; dd = $urandom;
        lk = $urandom_range(0, 3) == 0;
      end else if (pend && $urandom_range(0, 19) == 0) begin
        pend = 0;
      end
      drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            32'($urandom_range(0, 15)) << 2, $urandom, pend, dw, da, dd, lk);
      total++;
      if ({dbg_gnt, core_stall, mem_read, mem_write} !== {exp_gnt, exp_stall, exp_mr, exp_mw} ||
          mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_store_type !== exp_st ||
          mem_load_type !== exp_lt || core_rdata !== tb_mem[exp_addr[9:2]]) begin
        bad++;
        $display("FAIL random_comb c=%0d: gnt/stall/rd/we=%b%b%b%b want %b%b%b%b addr=%h want %h",
                 c, dbg_gnt, core_stall, mem_read, mem_write, exp_gnt, exp_stall, exp_mr, exp_mw,
                 mem_addr, exp_addr);
      end
      if (exp_gnt) pend = 0;
      tick();
      total++;
      if (dbg_rvalid !== m_rvalid || (m_rvalid && dbg_rdata !== m_rdata)) begin
        bad++;
        $display("FAIL random_rdata c=%0d: rvalid=%b rdata=%h want %b/%h", c,
                 dbg_rvalid, dbg_rdata, m_rvalid, m_rdata);
      end
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (tb_mem[i] !== ref_mem[i]) begin
        bad++;
        $display("FAIL random_mem word=%0d: mem=%h want %h", i, tb_mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    test_reset();
    test_uncontested();
    test_contested_load();
    idle();
    test_contested_store();
    idle();
    test_drop_before_grant();
    test_reset_pending();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
    idle();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
